// File: rtl/imem_encoder_loader.sv
// Sequential instruction encoder: packs decoded field tuples into 32-bit words
// and writes them to consecutive imem addresses during a load session.
module imem_encoder_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_opcode,
    input  logic [4:0]            in_func,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_shamt,
    input  logic [16:0]           in_imm,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] FUNC_SRA = 5'b00101;  // highest legal ALU func code

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  enc_legal;
    logic [31:0]           enc_word;
    logic [31:0]           word_q;
    logic                  last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  addr_at_top;
    logic                  start_ok;
    logic                  handshake;

    // Field packing and legality check for the tuple currently presented.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        enc_legal = 1'b0;
        enc_word  = '0;
        case (in_opcode)
            OP_RTYPE: begin
                enc_legal = (in_func <= FUNC_SRA);
                enc_word  = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_func, 2'b00};
            end
            OP_ADDI, OP_SW, OP_LW: begin
                enc_legal = 1'b1;
                enc_word  = {in_opcode, in_rd, in_rs, in_imm};
            end
            default: begin
                enc_legal = 1'b0;
                enc_word  = '0;
            end
        endcase
    end

    assign addr_at_top = (addr_q == '1);
    assign start_ok    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign handshake   = in_valid && (state_q == S_ACCEPT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    if (enc_legal)    state_d = S_WRITE;
                    else if (in_last) state_d = S_DONE;
                end
            end
            S_WRITE: begin
                // A last word that lands on the top address finishes without flagging full.
                if (last_q || addr_at_top) state_d = S_DONE;
                else                       state_d = S_ACCEPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        imem_we  = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                busy    = 1'b1;
                imem_we = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Session datapath: word/last capture, address and count, sticky flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            last_q <= 1'b0;
            addr_q <= '0;
            count  <= '0;
            err    <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (start_ok) begin
                addr_q <= BASE;
                count  <= '0;
                err    <= 1'b0;
                full   <= 1'b0;
            end
            if (handshake) begin
                if (enc_legal) begin
                    word_q <= enc_word;
                    last_q <= in_last;
                end else begin
                    err <= 1'b1;
                end
            end
            if (state_q == S_WRITE) begin
                count <= count + (ADDR_WIDTH + 1)'(1);
                if (!addr_at_top) begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end else if (!last_q) begin
                    full <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = addr_q;
    assign imem_data = word_q;

endmodule

// File: tb/tb_imem_encoder_loader.sv
// Self-checking bench for imem_encoder_loader: directed and randomized sessions
// on a 12-bit and a 2-bit address instance against a behavioural session model.
module tb_imem_encoder_loader;

    localparam int AW_A = 12;
    localparam int AW_B = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [4:0] in_opcode = '0, in_func = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0;
    logic [16:0] in_imm = '0;

    logic in_ready_a, imem_we_a, busy_a, done_a, err_a, full_a;
    logic [AW_A-1:0] imem_addr_a;
    logic [31:0] imem_data_a;
    logic [AW_A:0] count_a;

    logic in_ready_b, imem_we_b, busy_b, done_b, err_b, full_b;
    logic [AW_B-1:0] imem_addr_b;
    logic [31:0] imem_data_b;
    logic [AW_B:0] count_b;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  func;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [16:0] imm;
        bit          last;
    } tuple_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    tuple_t tq[$];
    wr_t    obs_a[$];
    wr_t    obs_b[$];

    imem_encoder_loader #(.ADDR_WIDTH(AW_A), .BASE_ADDR(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_opcode(in_opcode), .in_func(in_func), .in_rd(in_rd),
        .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we_a), .imem_addr(imem_addr_a),
        .imem_data(imem_data_a), .busy(busy_a), .done(done_a), .err(err_a),
        .full(full_a), .count(count_a)
    );

    imem_encoder_loader #(.ADDR_WIDTH(AW_B), .BASE_ADDR(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_opcode(in_opcode), .in_func(in_func), .in_rd(in_rd),
        .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
        .imem_data(imem_data_b), .busy(busy_b), .done(done_b), .err(err_b),
        .full(full_b), .count(count_b)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writes observed on each instance, plus the handshake being closed during writes.
    always @(negedge clock) begin
        if (imem_we_a) begin
            obs_a.push_back('{int'(imem_addr_a), imem_data_a});
            check("write_cycle_ready_busy_a", {62'd0, in_ready_a, busy_a}, 64'd1);
        end
        if (imem_we_b) begin
            obs_b.push_back('{int'(imem_addr_b), imem_data_b});
            check("write_cycle_ready_busy_b", {62'd0, in_ready_b, busy_b}, 64'd1);
        end
    end

    function automatic tuple_t mk(input int op, input int func, input int rd, input int rs,
                                  input int rt, input int shamt, input int imm, input bit last);
        tuple_t t;
        t.op = 5'(op); t.func = 5'(func); t.rd = 5'(rd); t.rs = 5'(rs);
        t.rt = 5'(rt); t.shamt = 5'(shamt); t.imm = 17'(imm); t.last = last;
        return t;
    endfunction

    // Reference encoding computed from the field positions with plain arithmetic.
    function automatic void model_encode(input tuple_t t, output bit legal, output logic [31:0] w);
        longint unsigned v;
        legal = 1'b0;
        v = 0;
        if (t.op == 0) begin
            legal = (t.func < 6);
            v = t.op * 2**27 + t.rd * 2**22 + t.rs * 2**17 + t.rt * 2**12
                + t.shamt * 2**7 + t.func * 4;
        end else if (t.op == 5 || t.op == 7 || t.op == 8) begin
            legal = 1'b1;
            v = t.op * 2**27 + t.rd * 2**22 + t.rs * 2**17 + t.imm;
        end
        w = v[31:0];
    endfunction

    function automatic tuple_t rand_tuple(input bit last);
        tuple_t t;
        int sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3: t.op = 5'd0;
            4:          t.op = 5'd5;
            5:          t.op = 5'd7;
            6:          t.op = 5'd8;
            default:    t.op = 5'($urandom);
        endcase
        t.func  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
        t.rd    = 5'($urandom);
        t.rs    = 5'($urandom);
        t.rt    = 5'($urandom);
        t.shamt = 5'($urandom);
        t.imm   = 17'($urandom);
        t.last  = last;
        return t;
    endfunction

    // Presents a tuple; reports whether a handshake happened within the bound.
    task automatic send(input int which, input tuple_t t, input int bound, output bit accepted);
        in_opcode = t.op; in_func = t.func; in_rd = t.rd; in_rs = t.rs;
        in_rt = t.rt; in_shamt = t.shamt; in_imm = t.imm; in_last = t.last;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if ((which == 0) ? in_ready_a : in_ready_b) begin
                @(posedge clock);
                accepted = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Runs the queued tuples as one session and compares against the session model.
    task automatic run_session(input int which, input string name);
        int unsigned maxa = (which == 0) ? (2**AW_A - 1) : (2**AW_B - 1);
        int unsigned a = 0;
        int cnt = 0;
        bit e = 0, f = 0, fin = 0, legal, acc;
        logic [31:0] w;
        wr_t exp_q[$];
        wr_t got_q[$];
        obs_a.delete();
        obs_b.delete();
        pulse_start(which);
        check({name, "_busy_after_start"}, (which == 0) ? busy_a : busy_b, 1);
        check({name, "_count_cleared"}, (which == 0) ? 64'(count_a) : 64'(count_b), 0);
        foreach (tq[i]) begin
            if (fin) begin
                send(which, tq[i], 6, acc);
                check({name, "_extra_not_accepted"}, acc, 0);
                break;
            end
            send(which, tq[i], 20, acc);
            check({name, "_accepted"}, acc, 1);
            model_encode(tq[i], legal, w);
            if (!legal) begin
                e = 1;
                if (tq[i].last) fin = 1;
            end else begin
                exp_q.push_back('{a, w});
                cnt++;
                if (tq[i].last) fin = 1;
                else if (a == maxa) begin f = 1; fin = 1; end
                else a++;
            end
        end
        repeat (3) @(negedge clock);
        got_q = (which == 0) ? obs_a : obs_b;
        check({name, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({name, "_waddr"}, got_q[i].addr, exp_q[i].addr);
            check({name, "_wdata"}, got_q[i].data, exp_q[i].data);
        end
        check({name, "_count"}, (which == 0) ? 64'(count_a) : 64'(count_b), cnt);
        check({name, "_err"}, (which == 0) ? err_a : err_b, e);
        check({name, "_full"}, (which == 0) ? full_a : full_b, f);
        check({name, "_done_busy"}, (which == 0) ? {done_a, busy_a} : {done_b, busy_b}, 2'b10);
    endtask

    initial begin
        bit acc;
        #12;
        check("reset_outputs_a", {in_ready_a, imem_we_a, imem_addr_a, imem_data_a, busy_a,
                                  done_a, err_a, full_a, count_a}, 0);
        check("reset_outputs_b", {in_ready_b, imem_we_b, imem_addr_b, imem_data_b, busy_b,
                                  done_b, err_b, full_b, count_b}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        tq = '{mk(0, 0, 3, 1, 2, 0, 0, 1)};
        run_session(0, "add");
        check("add_word", obs_a[0].data, 32'h00C22000);

        tq = '{mk(5, 0, 1, 0, 0, 0, 5, 0), mk(0, 4, 4, 3, 0, 2, 0, 1)};
        run_session(0, "addi_sll");
        check("addi_word", obs_a[0].data, 32'h28400005);
        check("sll_word", obs_a[1].data, 32'h01060110);

        tq = '{mk(8, 0, 2, 1, 0, 0, 17'h1FFFF, 1)};
        run_session(0, "lw");
        check("lw_word", obs_a[0].data, 32'h4083FFFF);

        tq = '{mk(0, 0, 1, 2, 3, 0, 0, 0), mk(31, 0, 1, 1, 1, 0, 0, 0), mk(0, 1, 5, 6, 7, 0, 0, 1)};
        run_session(0, "illegal_op");
        tq = '{mk(7, 0, 9, 2, 0, 0, 12, 0), mk(0, 15, 1, 1, 1, 0, 0, 0), mk(0, 3, 5, 6, 7, 0, 0, 1)};
        run_session(0, "illegal_func");
        check("illegal_func_addr1", obs_a[1].addr, 1);

        tq = '{mk(0, 2, 1, 1, 1, 0, 0, 0), mk(31, 0, 1, 1, 1, 0, 0, 1), mk(5, 0, 1, 1, 1, 0, 0, 1)};
        run_session(0, "illegal_last");

        tq.delete();
        for (int i = 0; i < 5; i++) tq.push_back(mk(5, 0, i, i + 1, 0, 0, 100 + i, 0));
        run_session(1, "full");
        check("full_last_addr", obs_b[3].addr, 3);

        tq = '{mk(7, 0, 1, 2, 0, 0, 3, 1), mk(7, 0, 4, 5, 0, 0, 6, 1)};
        run_session(1, "small_last");

        // Reset asserted while a write is in progress.
        obs_a.delete();
        pulse_start(0);
        in_opcode = 5'd0; in_func = 5'd1; in_rd = 5'd7; in_rs = 5'd2; in_rt = 5'd3;
        in_shamt = 5'd0; in_imm = '0; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clock);
        #1;
        check("write_before_reset", imem_we_a, 1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_write_outputs", {in_ready_a, imem_we_a, imem_addr_a, imem_data_a, busy_a,
                                          done_a, err_a, full_a, count_a}, 0);
        @(negedge clock);
        in_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        check("after_reset_outputs", {in_ready_a, imem_we_a, imem_addr_a, imem_data_a, busy_a,
                                      done_a, err_a, full_a, count_a}, 0);
        check("no_write_after_reset", obs_a.size(), 0);
        send(0, mk(5, 0, 1, 1, 0, 0, 9, 1), 4, acc);
        check("idle_ignores_valid", acc, 0);
        check("idle_no_write", obs_a.size(), 0);
        tq = '{mk(0, 5, 8, 9, 10, 11, 0, 1)};
        run_session(0, "after_reset");

        for (int s = 0; s < 25; s++) begin
            int n = $urandom_range(1, 7);
            tq.delete();
            for (int i = 0; i < n; i++) tq.push_back(rand_tuple(i == n - 1));
            run_session(0, "rand_a");
        end
        for (int s = 0; s < 6; s++) begin
            int n = $urandom_range(1, 6);
            tq.delete();
            for (int i = 0; i < n; i++) tq.push_back(rand_tuple(i == n - 1));
            run_session(1, "rand_b");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
